// File: rtl/playback_reader.sv
// playback_reader: replays recorded note words from the note RAM, one per tempo beat.
// Optional feature: define LOOP_PLAYBACK_EN to wrap to address 0 after the last word
// and keep playing until stop, instead of ending with a done pulse.
module playback_reader #(
   parameter int ADDR_W     = 6,
   parameter int DATA_W     = 32,
   parameter int CNT_W      = 27,
   parameter int GAP_CYCLES = 10000,
   parameter int PERIOD_DIV = 1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic              stop,
   input  logic [2:0]        speed,
   input  logic [ADDR_W:0]   length,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] note,
   output logic              note_on,
   output logic              beat,
   output logic              playing,
   output logic              done
);
   typedef enum logic [2:0] {IDLE, FETCH, LATCH, PLAY, DONE} state_t;

   localparam logic [31:0] TEMPO [8] = '{32'd75000000, 32'd50000000, 32'd37500000, 32'd30000000,
                                         32'd25000000, 32'd21428571, 32'd16666667, 32'd13636364};
   localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   note_q, note_d;
   logic                done_q, done_d;
   logic [CNT_W-1:0]    period_m1;
   logic [ADDR_W:0]     len_eff;
   logic                last;

   assign period_m1 = CNT_W'(TEMPO[speed] / 32'(PERIOD_DIV) - 32'd1);
   assign len_eff   = (length > DEPTH) ? DEPTH : length;
   assign last      = {1'b0, addr_q} == len_eff - 1'b1;
   assign playing   = state_q != IDLE;
   assign beat      = playing && cnt_q == '0;
   assign mem_rd    = state_q == FETCH;
   assign mem_addr  = addr_q;
   assign note      = note_q;
   assign note_on   = state_q == PLAY && cnt_q >= CNT_W'(GAP_CYCLES);
   assign done      = done_q | (state_q == DONE && !stop);

   // Next-state, address walk, tempo counter and note latch; stop overrides everything.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      note_d  = note_q;
      done_d  = 1'b0;
      if (playing) cnt_d = beat ? period_m1 : cnt_q - 1'b1;
      case (state_q)
         IDLE: if (start && !stop) begin
            if (len_eff == '0) done_d = 1'b1;
            else begin
               state_d = FETCH;
               addr_d  = '0;
               cnt_d   = period_m1;
            end
         end
         FETCH: state_d = LATCH;
         LATCH: begin
            state_d = PLAY;
            note_d  = mem_rdata;
         end
         PLAY: if (beat) begin
            if (last) begin
`ifdef LOOP_PLAYBACK_EN
               addr_d  = '0;
               state_d = FETCH;
`else
               state_d = DONE;
`endif
            end else begin
               addr_d  = addr_q + 1'b1;
               state_d = FETCH;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (stop && playing) begin
         state_d = IDLE;
         note_d  = note_q;
      end
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         note_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         note_q  <= note_d;
         done_q  <= done_d;
      end
   end
endmodule

// File: tb/tb_playback_reader.sv
// tb_playback_reader: randomized self-checking bench for playback_reader with a beat-timeline model.
module tb_playback_reader;
   localparam int AW  = 6;
   localparam int DW  = 32;
   localparam int CW  = 27;
   localparam int GAP = 4;
   localparam int DIV = 1000000;

   logic          clk = 1'b0;
   logic          resetn, start, stop;
   logic [2:0]    speed;
   logic [AW:0]   length;
   logic          mem_rd;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rdata = '0;
   logic [DW-1:0] note;
   logic          note_on, beat, playing, done;

   logic [DW-1:0] ram [64];
   logic [DW-1:0] held = '0;
   int unsigned   tempo [8] = '{75000000, 50000000, 37500000, 30000000,
                                25000000, 21428571, 16666667, 13636364};
   int vectors = 0;
   int miscompares = 0;

   playback_reader #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .GAP_CYCLES(GAP), .PERIOD_DIV(DIV)) dut (
      .clk(clk), .resetn(resetn), .start(start), .stop(stop), .speed(speed), .length(length),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .note(note),
      .note_on(note_on), .beat(beat), .playing(playing), .done(done));

   always #5 clk = ~clk;

   always @(posedge clk) if (mem_rd) mem_rdata <= ram[mem_addr];

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic expect_cycle(input string tag, input logic rd, input logic [DW-1:0] addr,
                               input logic [DW-1:0] nt, input logic on, input logic bt,
                               input logic pl, input logic dn);
      check({tag, ".mem_rd"}, DW'(mem_rd), DW'(rd));
      if (rd) check({tag, ".mem_addr"}, DW'(mem_addr), addr);
      check({tag, ".note"}, note, nt);
      check({tag, ".note_on"}, DW'(note_on), DW'(on));
      check({tag, ".beat"}, DW'(beat), DW'(bt));
      check({tag, ".playing"}, DW'(playing), DW'(pl));
      check({tag, ".done"}, DW'(done), DW'(dn));
   endtask

   task automatic step(input logic st, input logic sp);
      start = st;
      stop  = sp;
      @(posedge clk);
      #1;
      start = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic fill_ram();
      for (int i = 0; i < 64; i++) ram[i] = $urandom;
   endtask

   // One playback: cycle k after the start edge sits in beat k/p at phase k%p.
   task automatic run(input int sp, input int n_raw, input int stop_in, input bit extra);
      int p, n, stop_at, last_k, b, ph, bi;
      logic fin;
      logic [DW-1:0] cur, exp_note;
      string tag;
      p = int'(tempo[sp] / DIV);
      n = n_raw > 64 ? 64 : n_raw;
      stop_at = stop_in;
      speed = 3'(sp);
      length = (AW+1)'(n_raw);
      if (n == 0) begin
         step(1'b1, 1'b0);
         expect_cycle("len0.pulse", 1'b0, '0, held, 1'b0, 1'b0, 1'b0, 1'b1);
         step(1'b0, 1'b0);
         expect_cycle("len0.after", 1'b0, '0, held, 1'b0, 1'b0, 1'b0, 1'b0);
         return;
      end
`ifdef LOOP_PLAYBACK_EN
      if (stop_at == 0) stop_at = 3 * n * p + 5;
`endif
      last_k = stop_at != 0 ? stop_at : n * p + 1;
      cur = held;
      for (int k = 0; k <= last_k; k++) begin
         step(k == 0 || (extra && $urandom_range(7) == 0), stop_at != 0 && k == stop_at);
         tag = $sformatf("sp%0d.n%0d.k%0d", sp, n_raw, k);
         fin = 1'b0;
`ifndef LOOP_PLAYBACK_EN
         fin = k >= n * p;
`endif
         if (stop_at != 0 && k == stop_at)
            expect_cycle({tag, ".stopped"}, 1'b0, '0, cur, 1'b0, 1'b0, 1'b0, 1'b0);
         else if (fin && k == n * p)
            expect_cycle({tag, ".done"}, 1'b0, '0, cur, 1'b0, 1'b0, 1'b1, 1'b1);
         else if (fin)
            expect_cycle({tag, ".idle"}, 1'b0, '0, cur, 1'b0, 1'b0, 1'b0, 1'b0);
         else begin
            b  = k / p;
            ph = k % p;
            bi = b % n;
            exp_note = ph >= 2 ? ram[bi] : cur;
            cur = exp_note;
            expect_cycle(tag, ph == 0, DW'(bi), exp_note, ph >= 2 && (p - 1 - ph) >= GAP,
                         ph == p - 1, 1'b1, 1'b0);
         end
      end
      held = cur;
   endtask

   initial begin
      resetn = 1'b0;
      start  = 1'b0;
      stop   = 1'b0;
      speed  = '0;
      length = '0;
      fill_ram();
      repeat (2) @(posedge clk);
      #1;
      expect_cycle("reset", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      resetn = 1'b1;
      step(1'b0, 1'b0);
      expect_cycle("reset.idle", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      run(1, 3, 0, 1'b0);
      run(1, 0, 0, 1'b0);
      fill_ram();
      run(7, 5, 20, 1'b0);
      run(7, 3, 0, 1'b1);
      fill_ram();
      run(7, 70, 0, 1'b0);
      run(1, 2, 0, 1'b0);
      for (int t = 0; t < 15; t++) begin
         int sp, n, s;
         fill_ram();
         sp = int'($urandom_range(7));
         n  = int'($urandom_range(6, 1));
         s  = $urandom_range(1) == 1 ? int'($urandom_range(n * int'(tempo[sp] / DIV), 1)) : 0;
         run(sp, n, s, 1'b1);
      end
      speed  = 3'd7;
      length = 7'd4;
      step(1'b1, 1'b0);
      repeat (9) step(1'b0, 1'b0);
      #2;
      resetn = 1'b0;
      #1;
      expect_cycle("async_reset", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      expect_cycle("async_reset.hold", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      resetn = 1'b1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
